// File: rtl/lt24_touch_pkg.sv
// rtl/lt24_touch_pkg.sv - shared types and constants for the LT24 touch reader
// Purpose: FSM state encodings, ADS7843 command bytes, frame geometry and
//          default timing parameters used by lt24_touch_reader and ads7843_xfer.
// Ports:   none (package).
package lt24_touch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    CONV_X,
    CONV_Y,
    CHECK,
    GAP
  } state_t;

  typedef enum logic [1:0] {
    XF_IDLE,
    XF_RUN,
    XF_GUARD
  } xfer_state_t;

  // 12-bit mode, differential reference, power-down bits PD=00
  localparam logic [7:0] CMD_X = 8'hD0;
  localparam logic [7:0] CMD_Y = 8'h90;

  localparam int FRAME_LEN  = 24;
  localparam int DATA_FIRST = 9;
  localparam int DATA_LAST  = 20;
  localparam int RESULT_W   = 12;

  localparam int DEF_CLK_DIV      = 25;
  localparam int DEF_DEBOUNCE_CYC = 50000;
  localparam int DEF_GAP_CYC      = 500000;

endpackage

// File: rtl/ads7843_xfer.sv
// rtl/ads7843_xfer.sv - one 24-DCLK ADS7843 SPI conversion frame
// Purpose: on start (accepted while ready) drives one frame: command byte MSB
//          first on DCLK periods 0-7, captures D11..D0 on the rising edges of
//          periods 9-20, then raises cs_n and pulses done with the result.
//          cs_n is then held high for one extra DCLK half-period before the
//          next frame may begin.
// Ports:   clk, reset (sync, active-low)
//          start, cmd[7:0]   - frame request and command byte
//          sdo               - synchronized ADC serial data
//          ready             - idle, a start will be accepted
//          done, result[11:0]- one-cycle completion pulse and captured code
//          cs_n, dclk, din   - SPI bus to the ADS7843
module ads7843_xfer
  import lt24_touch_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          cmd,
  input  logic                sdo,
  output logic                ready,
  output logic                done,
  output logic [RESULT_W-1:0] result,
  output logic                cs_n,
  output logic                dclk,
  output logic                din
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0] IDX_FIRST = 5'(DATA_FIRST);
  localparam logic [4:0] IDX_LAST  = 5'(DATA_LAST);
  localparam logic [4:0] IDX_END   = 5'(FRAME_LEN - 1);

  xfer_state_t         xs_q, xs_d;
  logic [DIV_W-1:0]    half_q, half_d;
  logic [4:0]          idx_q, idx_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [RESULT_W-1:0] shift_q, shift_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic                cs_n_q, cs_n_d;
  logic                dclk_q, dclk_d;
  logic                din_q, din_d;
  logic                done_q, done_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      xs_q     <= XF_IDLE;
      half_q   <= '0;
      idx_q    <= '0;
      cmd_q    <= '0;
      shift_q  <= '0;
      result_q <= '0;
      cs_n_q   <= 1'b1;
      dclk_q   <= 1'b0;
      din_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      xs_q     <= xs_d;
      half_q   <= half_d;
      idx_q    <= idx_d;
      cmd_q    <= cmd_d;
      shift_q  <= shift_d;
      result_q <= result_d;
      cs_n_q   <= cs_n_d;
      dclk_q   <= dclk_d;
      din_q    <= din_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    xs_d     = xs_q;
    half_d   = half_q;
    idx_d    = idx_q;
    cmd_d    = cmd_q;
    shift_d  = shift_q;
    result_d = result_q;
    cs_n_d   = cs_n_q;
    dclk_d   = dclk_q;
    din_d    = din_q;
    done_d   = 1'b0;
    case (xs_q)
      XF_IDLE: begin
        if (start) begin
          // First command bit is set up before the first rising edge; the
          // divider restarts here so every frame has identical timing.
          xs_d    = XF_RUN;
          half_d  = '0;
          idx_d   = '0;
          shift_d = '0;
          cs_n_d  = 1'b0;
          dclk_d  = 1'b0;
          din_d   = cmd[7];
          cmd_d   = {cmd[6:0], 1'b0};
        end
      end
      XF_RUN: begin
        if (half_q == HALF_LAST) begin
          half_d = '0;
          dclk_d = ~dclk_q;
          if (!dclk_q) begin
            if (idx_q >= IDX_FIRST && idx_q <= IDX_LAST) begin
              shift_d = {shift_q[RESULT_W-2:0], sdo};
            end
          end else if (idx_q == IDX_END) begin
            xs_d     = XF_GUARD;
            cs_n_d   = 1'b1;
            din_d    = 1'b0;
            result_d = shift_q;
            done_d   = 1'b1;
          end else begin
            // Zeros shifted in behind the command keep din low afterwards.
            idx_d = idx_q + 5'd1;
            din_d = cmd_q[7];
            cmd_d = {cmd_q[6:0], 1'b0};
          end
        end else begin
          half_d = half_q + DIV_W'(1);
        end
      end
      XF_GUARD: begin
        if (half_q == HALF_LAST) begin
          xs_d   = XF_IDLE;
          half_d = '0;
        end else begin
          half_d = half_q + DIV_W'(1);
        end
      end
      default: xs_d = XF_IDLE;
    endcase
  end

  assign ready  = (xs_q == XF_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign cs_n   = cs_n_q;
  assign dclk   = dclk_q;
  assign din    = din_q;

endmodule

// File: rtl/lt24_touch_reader.sv
// rtl/lt24_touch_reader.sv - LT24 ADS7843 touch position reader
// Purpose: debounces PENIRQ, then repeatedly converts X and Y while the pen
//          stays down, publishing each valid pair with a one-cycle pos_ready.
// Ports:   clk, reset (sync, active-low), en - sampling enable
//          touch_irq_n - async PENIRQ (low = pen down)
//          adc_cs_n, adc_dclk, adc_din - SPI outputs; adc_dout - async SPI input
//          pos_ready - new-pair pulse; x_pos, y_pos - raw 12-bit codes (held)
module lt24_touch_reader
  import lt24_touch_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int GAP_CYC      = DEF_GAP_CYC
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                touch_irq_n,
  output logic                adc_cs_n,
  output logic                adc_dclk,
  output logic                adc_din,
  input  logic                adc_dout,
  output logic                pos_ready,
  output logic [RESULT_W-1:0] x_pos,
  output logic [RESULT_W-1:0] y_pos
);

  // One counter serves both debounce and gap, sized for the larger count.
  localparam int CNT_MAX = (DEBOUNCE_CYC > GAP_CYC) ? DEBOUNCE_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

  // The pen chain carries the inverted IRQ so its cleared state means pen-up.
  logic pen_meta, pen_down;
  logic dout_meta, dout_sync;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pen_meta  <= 1'b0;
      pen_down  <= 1'b0;
      dout_meta <= 1'b0;
      dout_sync <= 1'b0;
    end else begin
      pen_meta  <= ~touch_irq_n;
      pen_down  <= pen_meta;
      dout_meta <= adc_dout;
      dout_sync <= dout_meta;
    end
  end

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                issued_q;
  logic [RESULT_W-1:0] x_code_q, y_code_q;
  logic                pos_ready_d;
  logic [RESULT_W-1:0] x_pos_d, y_pos_d;

  logic                xfer_start, xfer_ready, xfer_done;
  logic [7:0]          xfer_cmd;
  logic [RESULT_W-1:0] xfer_result;

  // Request a frame once per conversion state; the request waits while the
  // transfer block is still holding cs_n high after the previous frame.
  assign xfer_start = (state_q == CONV_X || state_q == CONV_Y) && !issued_q;
  assign xfer_cmd   = (state_q == CONV_Y) ? CMD_Y : CMD_X;

  ads7843_xfer #(
    .CLK_DIV (CLK_DIV)
  ) u_xfer (
    .clk    (clk),
    .reset  (reset),
    .start  (xfer_start),
    .cmd    (xfer_cmd),
    .sdo    (dout_sync),
    .ready  (xfer_ready),
    .done   (xfer_done),
    .result (xfer_result),
    .cs_n   (adc_cs_n),
    .dclk   (adc_dclk),
    .din    (adc_din)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      issued_q  <= 1'b0;
      x_code_q  <= '0;
      y_code_q  <= '0;
      pos_ready <= 1'b0;
      x_pos     <= '0;
      y_pos     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pos_ready <= pos_ready_d;
      x_pos     <= x_pos_d;
      y_pos     <= y_pos_d;
      if (xfer_done) begin
        issued_q <= 1'b0;
      end else if (xfer_start && xfer_ready) begin
        issued_q <= 1'b1;
      end
      if (xfer_done && state_q == CONV_X) begin
        x_code_q <= xfer_result;
      end
      if (xfer_done && state_q == CONV_Y) begin
        y_code_q <= xfer_result;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pos_ready_d = 1'b0;
    x_pos_d     = x_pos;
    y_pos_d     = y_pos;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en && pen_down) begin
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!pen_down) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = CONV_X;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // Frames always run to completion; pen-up or en=0 is judged in CHECK.
      CONV_X: begin
        if (xfer_done) begin
          state_d = CONV_Y;
        end
      end
      CONV_Y: begin
        if (xfer_done) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        cnt_d = '0;
        if (pen_down && en) begin
          x_pos_d     = x_code_q;
          y_pos_d     = y_code_q;
          pos_ready_d = 1'b1;
          state_d     = GAP;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = (pen_down && en) ? CONV_X : IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_lt24_touch_reader.sv
// tb/tb_lt24_touch_reader.sv - directed self-checking bench for lt24_touch_reader
module tb_lt24_touch_reader;

  localparam int CLK_DIV = 4;
  localparam int DEB     = 200;
  localparam int GAP     = 1000;
  localparam int FRAME   = 24 * 2 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        touch_irq_n = 1'b1;
  logic        adc_dout = 1'b0;
  logic        adc_cs_n, adc_dclk, adc_din, pos_ready;
  logic [11:0] x_pos, y_pos;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ADC model data, consumed in frame order (X table for D0, Y table for 90)
  logic [11:0] x_vals [0:8] = '{12'hA5C, 12'h800, 12'h000, 12'hFFF, 12'h123,
                                12'h111, 12'h234, 12'h6AB, 12'h0AB};
  logic [11:0] y_vals [0:8] = '{12'h3F1, 12'hFFF, 12'h001, 12'h800, 12'h456,
                                12'h567, 12'h7CD, 12'h0CD, 12'h000};
  int          x_ptr = 0, y_ptr = 0;
  logic [11:0] cur_data = '0;
  logic [7:0]  cmd_rx = '0;
  logic [7:0]  cmd_log [0:31];
  int          n_frames = 0, rise_cnt = 0, fall_cnt = 0;
  int          cs_falls = 0, cs_rises = 0, last_rises = 0, last_rise_cyc = 0;
  int          fall_cyc [0:31];
  int          fall_gap [0:31];
  int          pulse_cnt = 0;
  logic [11:0] pulse_x [0:15];
  logic [11:0] pulse_y [0:15];
  int          pulse_cyc [0:15];
  int          pulse_lat [0:15];
  logic        cs_prev = 1'b1, dclk_prev = 1'b0;

  int base_n, base_p, base_f, base_r, t_pen, t_rel;

  lt24_touch_reader #(
    .CLK_DIV      (CLK_DIV),
    .DEBOUNCE_CYC (DEB),
    .GAP_CYC      (GAP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .touch_irq_n (touch_irq_n),
    .adc_cs_n    (adc_cs_n),
    .adc_dclk    (adc_dclk),
    .adc_din     (adc_din),
    .adc_dout    (adc_dout),
    .pos_ready   (pos_ready),
    .x_pos       (x_pos),
    .y_pos       (y_pos)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // ADS7843 model and bus monitor, sampled on the falling clk edge.
  initial forever begin
    @(negedge clk);
    if (cs_prev === 1'b1 && adc_cs_n === 1'b0) begin
      if (cs_falls < 32) begin
        fall_cyc[cs_falls] = cyc;
        fall_gap[cs_falls] = cyc - last_rise_cyc;
      end
      cs_falls = cs_falls + 1;
      rise_cnt = 0;
      fall_cnt = 0;
      adc_dout = 1'b0;
    end
    if (cs_prev === 1'b0 && adc_cs_n === 1'b1) begin
      cs_rises = cs_rises + 1;
      last_rises = rise_cnt;
      last_rise_cyc = cyc;
    end
    if (adc_cs_n === 1'b0 && dclk_prev === 1'b0 && adc_dclk === 1'b1) begin
      rise_cnt = rise_cnt + 1;
      if (rise_cnt <= 8) cmd_rx = {cmd_rx[6:0], adc_din};
      if (rise_cnt == 8) begin
        if (n_frames < 32) cmd_log[n_frames] = cmd_rx;
        if (cmd_rx == 8'hD0) begin
          cur_data = x_vals[x_ptr];
          x_ptr = x_ptr + 1;
        end else begin
          cur_data = y_vals[y_ptr];
          y_ptr = y_ptr + 1;
        end
        n_frames = n_frames + 1;
      end
    end
    if (adc_cs_n === 1'b0 && dclk_prev === 1'b1 && adc_dclk === 1'b0) begin
      fall_cnt = fall_cnt + 1;
      if (fall_cnt >= 9 && fall_cnt <= 20) adc_dout = cur_data[4'(20 - fall_cnt)];
      else adc_dout = 1'b0;
    end
    if (pos_ready === 1'b1 && pulse_cnt < 16) begin
      pulse_x[pulse_cnt]   = x_pos;
      pulse_y[pulse_cnt]   = y_pos;
      pulse_cyc[pulse_cnt] = cyc;
      pulse_lat[pulse_cnt] = cyc - last_rise_cyc;
      pulse_cnt = pulse_cnt + 1;
    end
    cs_prev = adc_cs_n;
    dclk_prev = adc_dclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int val, input int lo, input int hi);
    checks = checks + 1;
    assert (val >= lo && val <= hi) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0d expected range %0d..%0d", tag, val, lo, hi);
    end
  endtask

  task automatic wait_pulses(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (pulse_cnt < target && n < budget) begin
      @(negedge clk);
      n = n + 1;
    end
    chk_rng(tag, pulse_cnt, target, 1000);
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (n_frames < target && n < budget) begin
      @(negedge clk);
      n = n + 1;
    end
    chk_rng(tag, n_frames, target, 1000);
  endtask

  task automatic wait_rise(input string tag, input int frames, input int rises, input int budget);
    int n;
    n = 0;
    while (!(n_frames == frames && rise_cnt >= rises) && n < budget) begin
      @(negedge clk);
      n = n + 1;
    end
    chk_rng(tag, rise_cnt, rises, rises + 1);
  endtask

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_cs_n", adc_cs_n, 1);
    chk("rst_dclk", adc_dclk, 0);
    chk("rst_din", adc_din, 0);
    chk("rst_pos_ready", pos_ready, 0);
    chk("rst_x_pos", x_pos, 0);
    chk("rst_y_pos", y_pos, 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_cs_falls", cs_falls, 0);

    // Single sample: X=A5C, Y=3F1
    en = 1'b1;
    touch_irq_n = 1'b0;
    t_pen = cyc;
    wait_pulses("t1_wait_pulse", 1, 3000);
    touch_irq_n = 1'b1;
    repeat (GAP + 300) @(negedge clk);
    chk("t1_pulses", pulse_cnt, 1);
    chk("t1_pulse_x", pulse_x[0], 12'hA5C);
    chk("t1_pulse_y", pulse_y[0], 12'h3F1);
    chk("t1_x_pos", x_pos, 12'hA5C);
    chk("t1_y_pos", y_pos, 12'h3F1);
    chk("t1_frames", n_frames, 2);
    chk("t1_cmd_x", cmd_log[0], 8'hD0);
    chk("t1_cmd_y", cmd_log[1], 8'h90);
    chk("t1_frame_rises", last_rises, 24);
    chk_rng("t1_debounce", fall_cyc[0] - t_pen, DEB, DEB + 6);
    chk_rng("t1_latency", pulse_lat[0], 1, 3);
    chk_rng("t1_cs_gap", fall_gap[1], CLK_DIV, 1000);

    // Short pen-down glitch
    base_f = cs_falls;
    base_p = pulse_cnt;
    touch_irq_n = 1'b0;
    repeat (100) @(negedge clk);
    touch_irq_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("t2_cs_falls", cs_falls, base_f);
    chk("t2_pulses", pulse_cnt, base_p);
    chk("t2_cs_n", adc_cs_n, 1);

    // Three consecutive pairs
    base_p = pulse_cnt;
    base_n = n_frames;
    touch_irq_n = 1'b0;
    wait_pulses("t3_wait_pulses", base_p + 3, 8000);
    touch_irq_n = 1'b1;
    repeat (GAP + 300) @(negedge clk);
    chk("t3_pulses", pulse_cnt, base_p + 3);
    chk("t3_frames", n_frames, base_n + 6);
    chk("t3_p0_x", pulse_x[base_p], 12'h800);
    chk("t3_p0_y", pulse_y[base_p], 12'hFFF);
    chk("t3_p1_x", pulse_x[base_p + 1], 12'h000);
    chk("t3_p1_y", pulse_y[base_p + 1], 12'h001);
    chk("t3_p2_x", pulse_x[base_p + 2], 12'hFFF);
    chk("t3_p2_y", pulse_y[base_p + 2], 12'h800);
    chk("t3_cmd_x", cmd_log[base_n + 4], 8'hD0);
    chk("t3_cmd_y", cmd_log[base_n + 5], 8'h90);
    chk_rng("t3_space01", pulse_cyc[base_p + 1] - pulse_cyc[base_p], GAP + 2 * FRAME, 100000);
    chk_rng("t3_space12", pulse_cyc[base_p + 2] - pulse_cyc[base_p + 1], GAP + 2 * FRAME, 100000);
    chk_rng("t3_latency", pulse_lat[base_p + 2], 1, 3);

    // Pen released during the Y frame
    base_n = n_frames;
    base_r = cs_rises;
    base_p = pulse_cnt;
    touch_irq_n = 1'b0;
    wait_frames("t4_wait_y", base_n + 2, 2000);
    touch_irq_n = 1'b1;
    repeat (500) @(negedge clk);
    chk("t4_cs_rises", cs_rises, base_r + 2);
    chk("t4_y_rises", last_rises, 24);
    chk("t4_pulses", pulse_cnt, base_p);
    chk("t4_frames", n_frames, base_n + 2);
    chk("t4_x_pos", x_pos, 12'hFFF);
    chk("t4_y_pos", y_pos, 12'h800);
    chk("t4_cs_n", adc_cs_n, 1);

    // Reset at DCLK period 12 of the X frame
    base_n = n_frames;
    base_p = pulse_cnt;
    touch_irq_n = 1'b0;
    wait_rise("t5_wait_p12", base_n + 1, 13, 2000);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_cs_n", adc_cs_n, 1);
    chk("t5_dclk", adc_dclk, 0);
    chk("t5_din", adc_din, 0);
    chk("t5_pos_ready", pos_ready, 0);
    chk("t5_x_pos", x_pos, 0);
    chk("t5_y_pos", y_pos, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    t_rel = cyc;
    base_f = cs_falls;
    wait_pulses("t5_wait_pulse", base_p + 1, 3000);
    chk("t5_pulses", pulse_cnt, base_p + 1);
    chk("t5_pulse_x", pulse_x[base_p], 12'h234);
    chk("t5_pulse_y", pulse_y[base_p], 12'h567);
    chk_rng("t5_debounce", fall_cyc[base_f] - t_rel, DEB, DEB + 6);
    touch_irq_n = 1'b1;
    repeat (GAP + 300) @(negedge clk);

    // en dropped during the X frame
    base_n = n_frames;
    base_p = pulse_cnt;
    touch_irq_n = 1'b0;
    wait_frames("t6_wait_x", base_n + 1, 2000);
    en = 1'b0;
    repeat (1500) @(negedge clk);
    chk("t6_frames", n_frames, base_n + 2);
    chk("t6_pulses", pulse_cnt, base_p);
    chk("t6_x_pos", x_pos, 12'h234);
    chk("t6_y_pos", y_pos, 12'h567);
    repeat (1500) @(negedge clk);
    chk("t6_idle_frames", n_frames, base_n + 2);
    chk("t6_idle_cs_n", adc_cs_n, 1);
    en = 1'b1;
    wait_pulses("t6_wait_pulse", base_p + 1, 2000);
    chk("t6_pulse_x", pulse_x[base_p], 12'h0AB);
    chk("t6_pulse_y", pulse_y[base_p], 12'h0CD);
    touch_irq_n = 1'b1;
    repeat (GAP + 300) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
